// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared mixer constants and FSM state type
package mixer_pkg;

  localparam int MIX_N_VOICES  = 16;
  localparam int MIX_IN_WIDTH  = 32;
  localparam int MIX_OUT_WIDTH = 24;
  localparam int MIX_ACC_WIDTH = MIX_IN_WIDTH + $clog2(MIX_N_VOICES) + 9;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUTPUT
  } mixer_state_t;

endpackage

// File: rtl/sat_shift.sv
// rtl/sat_shift.sv - arithmetic right shift followed by signed saturation
module sat_shift #(
  parameter int IN_W  = 45,
  parameter int OUT_W = 24,
  parameter int SHIFT = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic signed [IN_W-1:0] MAX_VAL = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_VAL = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  assign shifted = din >>> SHIFT;

  // Clamp the shifted value into the output range and flag when clamping happened
  always_comb begin
    dout = shifted[OUT_W-1:0];
    clip = 1'b0;
    if (shifted > MAX_VAL) begin
      dout = MAX_VAL[OUT_W-1:0];
      clip = 1'b1;
    end else if (shifted < MIN_VAL) begin
      dout = MIN_VAL[OUT_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - serial voice summer with master volume and saturating output
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int N_VOICES  = MIX_N_VOICES,
  parameter int IN_WIDTH  = MIX_IN_WIDTH,
  parameter int OUT_WIDTH = MIX_OUT_WIDTH,
  parameter int ACC_WIDTH = IN_WIDTH + $clog2(N_VOICES) + 9
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_tick,
  input  logic [N_VOICES-1:0][IN_WIDTH-1:0]  voices_in,
  input  logic [N_VOICES-1:0]                voice_enable,
  input  logic [7:0]                         master_volume,
  output logic signed [OUT_WIDTH-1:0]        out_sample,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               clip,
  output logic                               overrun,
  output logic                               busy
);

  localparam int IDX_W = $clog2(N_VOICES);
  localparam int SHIFT = 8 + IN_WIDTH - OUT_WIDTH;

  mixer_state_t state, state_next;

  logic [N_VOICES-1:0][IN_WIDTH-1:0] voice_snap;
  logic [N_VOICES-1:0]               enable_snap;
  logic [7:0]                        vol_snap;
  logic [IDX_W-1:0]                  idx;
  logic signed [ACC_WIDTH-1:0]       acc;
  logic signed [ACC_WIDTH-1:0]       addend;
  logic signed [ACC_WIDTH-1:0]       gain;
  logic signed [ACC_WIDTH-1:0]       product;
  logic [8:0]                        gain9;
  logic signed [OUT_WIDTH-1:0]       sat_value;
  logic                              sat_clip;

  // Gain is volume+1 so that 255 maps to exactly unity after the >>8
  assign gain9   = {1'b0, vol_snap} + 9'd1;
  assign gain    = signed'({{(ACC_WIDTH-9){1'b0}}, gain9});
  assign product = acc * gain;
  assign busy    = (state != IDLE);

  // Select the current voice, sign-extended, or zero when it is disabled
  always_comb begin
    addend = '0;
    if (enable_snap[idx]) begin
      addend = signed'({{(ACC_WIDTH-IN_WIDTH){voice_snap[idx][IN_WIDTH-1]}}, voice_snap[idx]});
    end
  end

  sat_shift #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (OUT_WIDTH),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .din  (product),
    .dout (sat_value),
    .clip (sat_clip)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = ACCUM;
      ACCUM:   if (idx == IDX_W'(N_VOICES - 1)) state_next = SCALE;
      SCALE:   state_next = OUTPUT;
      OUTPUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot, accumulate, scale and hold the output sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voice_snap  <= '0;
      enable_snap <= '0;
      vol_snap    <= '0;
      idx         <= '0;
      acc         <= '0;
      out_sample  <= '0;
      out_valid   <= 1'b0;
      clip        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Any tick that arrives outside IDLE is dropped and reported
      overrun <= sample_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_tick) begin
            voice_snap  <= voices_in;
            enable_snap <= voice_enable;
            vol_snap    <= master_volume;
            acc         <= '0;
            idx         <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + addend;
          idx <= idx + 1'b1;
        end
        SCALE: begin
          out_sample <= sat_value;
          clip       <= sat_clip;
          out_valid  <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            clip      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - directed self-checking bench for voice_mixer
module tb_voice_mixer;

  logic                 clk;
  logic                 rst;
  logic                 sample_tick;
  logic [15:0][31:0]    voices_in;
  logic [15:0]          voice_enable;
  logic [7:0]           master_volume;
  logic signed [23:0]   out_sample;
  logic                 out_valid;
  logic                 out_ready;
  logic                 clip;
  logic                 overrun;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  voice_mixer dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .voices_in     (voices_in),
    .voice_enable  (voice_enable),
    .master_volume (master_volume),
    .out_sample    (out_sample),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .clip          (clip),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 16; i++) voices_in[i] = v;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      step(1);
    end
    chk(tag, longint'(out_valid), 1);
  endtask

  task automatic no_valid_for(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (out_valid) seen = 1'b1;
    end
    chk(tag, longint'(seen), 0);
  endtask

  longint held_sample;
  logic   stable;
  logic   ovr_seen_late;

  initial begin
    rst           = 1'b1;
    sample_tick   = 1'b0;
    voices_in     = '0;
    voice_enable  = '0;
    master_volume = 8'd0;
    out_ready     = 1'b1;
    step(3);
    chk("reset_out_sample", longint'(out_sample), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_clip", longint'(clip), 0);
    chk("reset_overrun", longint'(overrun), 0);
    chk("reset_busy", longint'(busy), 0);
    rst = 1'b0;
    step(2);

    // Unity gain, single voice, exact latency
    voices_in[0]  = 32'd65536;
    voice_enable  = 16'h0001;
    master_volume = 8'd255;
    tick();
    chk("busy_after_tick", longint'(busy), 1);
    step(16);
    chk("latency_not_early", longint'(out_valid), 0);
    step(1);
    chk("latency_valid_at_18", longint'(out_valid), 1);
    chk("unity_sample", longint'(out_sample), 256);
    chk("unity_clip", longint'(clip), 0);
    step(1);
    chk("handshake_valid_drop", longint'(out_valid), 0);
    chk("handshake_busy_drop", longint'(busy), 0);
    chk("sample_kept_after_hs", longint'(out_sample), 256);

    // Enable mask and half volume
    set_all(32'd1024);
    voice_enable  = 16'h0003;
    master_volume = 8'd127;
    tick();
    wait_valid("mask_timeout");
    chk("mask_sample", longint'(out_sample), 4);
    chk("mask_clip", longint'(clip), 0);
    step(2);

    // Minimum volume: gain of 1/256
    voices_in     = '0;
    voices_in[0]  = 32'd65536;
    voice_enable  = 16'h0001;
    master_volume = 8'd0;
    tick();
    wait_valid("vol0_timeout");
    chk("vol0_sample", longint'(out_sample), 1);
    step(2);

    // Arithmetic shift floors toward minus infinity
    voices_in[0]  = 32'hFFFF_FFFF;
    master_volume = 8'd255;
    tick();
    wait_valid("neg1_timeout");
    chk("neg1_sample", longint'(out_sample), -1);
    chk("neg1_clip", longint'(clip), 0);
    step(2);

    // All voices disabled
    set_all(32'd5000);
    voice_enable = 16'h0000;
    tick();
    wait_valid("disabled_timeout");
    chk("disabled_sample", longint'(out_sample), 0);
    chk("disabled_clip", longint'(clip), 0);
    step(2);

    // Positive saturation
    set_all(32'h4000_0000);
    voice_enable = 16'hFFFF;
    tick();
    wait_valid("satpos_timeout");
    chk("satpos_sample", longint'(out_sample), 8388607);
    chk("satpos_clip", longint'(clip), 1);
    step(1);
    chk("satpos_clip_cleared", longint'(clip), 0);
    step(1);

    // Negative saturation under backpressure with a dropped tick
    set_all(32'hC000_0000);
    out_ready = 1'b0;
    tick();
    wait_valid("bp_timeout");
    chk("satneg_sample", longint'(out_sample), -8388608);
    chk("satneg_clip", longint'(clip), 1);
    held_sample   = longint'(out_sample);
    stable        = 1'b1;
    ovr_seen_late = 1'b0;
    step(2);
    if (!out_valid || longint'(out_sample) != held_sample || !clip) stable = 1'b0;
    tick();
    chk("bp_overrun_pulse", longint'(overrun), 1);
    step(1);
    chk("bp_overrun_one_cycle", longint'(overrun), 0);
    for (int i = 0; i < 6; i++) begin
      if (!out_valid || longint'(out_sample) != held_sample || !clip) stable = 1'b0;
      if (overrun) ovr_seen_late = 1'b1;
      step(1);
    end
    chk("bp_hold_stable", longint'(stable), 1);
    chk("bp_no_extra_overrun", longint'(ovr_seen_late), 0);
    out_ready = 1'b1;
    step(1);
    chk("bp_release_valid", longint'(out_valid), 0);
    chk("bp_release_busy", longint'(busy), 0);
    no_valid_for("bp_no_second_sample", 25);

    // Tick coinciding with the handshake is dropped
    voices_in     = '0;
    voices_in[0]  = 32'd65536;
    voice_enable  = 16'h0001;
    out_ready     = 1'b0;
    tick();
    wait_valid("hs_tick_timeout");
    step(1);
    out_ready   = 1'b1;
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("hs_tick_overrun", longint'(overrun), 1);
    chk("hs_tick_valid_drop", longint'(out_valid), 0);
    chk("hs_tick_idle", longint'(busy), 0);
    no_valid_for("hs_tick_no_sample", 25);

    // Asynchronous reset in the middle of accumulation
    set_all(32'd7777);
    voice_enable = 16'hFFFF;
    tick();
    step(5);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", longint'(out_valid), 0);
    chk("rst_async_sample", longint'(out_sample), 0);
    chk("rst_async_busy", longint'(busy), 0);
    step(2);
    rst = 1'b0;
    no_valid_for("rst_no_partial", 25);
    voices_in     = '0;
    voices_in[0]  = 32'd65536;
    voice_enable  = 16'h0001;
    master_volume = 8'd255;
    tick();
    wait_valid("rst_recover_timeout");
    chk("rst_recover_sample", longint'(out_sample), 256);
    step(2);

    // Inputs changed mid-mix do not affect the result
    tick();
    step(2);
    voices_in[0]  = 32'd0;
    voice_enable  = 16'hFFFF;
    master_volume = 8'd0;
    wait_valid("midmix_timeout");
    chk("midmix_sample", longint'(out_sample), 256);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
